fetch_pair_buffer: RTL and testbench

Fetch stage directly downstream of the dual-issue PC generator. Each cycle it takes the PC pair (`pcF1`, `pcF2`), issues a paired read to the synchronous instruction memory, and captures the returned instruction pair. The pair is written into a small FIFO and presented to decode with a valid/ready handshake. It drives the PC generator's enable (`EN`) so that PCs only advance when a buffer slot is guaranteed, and it discards wrong-path work on a control-flow redirect.

---
 rtl/fetch_pair_if.sv | 31 +++
 rtl/fetch_pair_buffer.sv | 135 +++++++++++++
 tb/tb_fetch_pair_buffer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pair_if.sv
// Fetch-side bundle between PC generator, instruction memory, fetch buffer and decode.
// The master modport is the fetch buffer; slave is the surrounding pipeline/memory.
interface fetch_pair_if;
   logic [31:0] pcF1_i;
   logic [31:0] pcF2_i;
   logic        pc_en_o;
   logic        flush_i;
   logic        imem_rd_o;
   logic [31:0] imem_addr1_o;
   logic [31:0] imem_addr2_o;
   logic [31:0] imem_data1_i;
   logic [31:0] imem_data2_i;
   logic        dec_valid_o;
   logic        dec_ready_i;
   logic [31:0] dec_pc1_o;
   logic [31:0] dec_pc2_o;
   logic [31:0] dec_inst1_o;
   logic [31:0] dec_inst2_o;

   modport master (
      input  pcF1_i, pcF2_i, flush_i, imem_data1_i, imem_data2_i, dec_ready_i,
      output pc_en_o, imem_rd_o, imem_addr1_o, imem_addr2_o,
      output dec_valid_o, dec_pc1_o, dec_pc2_o, dec_inst1_o, dec_inst2_o
   );

   modport slave (
      output pcF1_i, pcF2_i, flush_i, imem_data1_i, imem_data2_i, dec_ready_i,
      input  pc_en_o, imem_rd_o, imem_addr1_o, imem_addr2_o,
      input  dec_valid_o, dec_pc1_o, dec_pc2_o, dec_inst1_o, dec_inst2_o
   );
endinterface

// File: rtl/fetch_pair_buffer.sv
// Dual-issue fetch buffer: paired imem reads, credit-gated PC advance, FIFO toward decode.
// Optional fetch stall counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_pair_buffer #(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_pair_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]  fetch_stall_cnt_o
`endif
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [31:0] pc1;
      logic [31:0] pc2;
      logic [31:0] inst1;
      logic [31:0] inst2;
   } entry_t;

   entry_t             fifoMem_q [DEPTH];
   entry_t             headEntry;
   logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   occupancy;
   logic               reqV_q, reqV_d;
   logic [31:0]        reqPc1_q, reqPc1_d;
   logic [31:0]        reqPc2_q, reqPc2_d;
   logic               pcEn;
   logic               decValid;
   logic               wrEn;
   logic               popEn;

   // Credit counts the in-flight read too, so a slot is reserved before the PC advances.
   always_comb begin
      occupancy = count_q + CNT_W'(reqV_q);
      pcEn      = rst_n & (bus.flush_i | (occupancy < CNT_W'(DEPTH)));
      decValid  = rst_n & (count_q != '0) & ~bus.flush_i;
      wrEn      = reqV_q & ~bus.flush_i;
      popEn     = decValid & bus.dec_ready_i;
   end

   always_comb begin
      wrPtr_d  = wrPtr_q;
      rdPtr_d  = rdPtr_q;
      count_d  = count_q;
      reqV_d   = 1'b0;
      reqPc1_d = reqPc1_q;
      reqPc2_d = reqPc2_q;
      if (bus.flush_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         reqV_d = pcEn;
         if (pcEn) begin
            reqPc1_d = bus.pcF1_i;
            reqPc2_d = bus.pcF2_i;
         end
         if (wrEn) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
         end
         if (popEn) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
         end
         case ({wrEn, popEn})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wrPtr_q  <= '0;
         rdPtr_q  <= '0;
         count_q  <= '0;
         reqV_q   <= 1'b0;
         reqPc1_q <= '0;
         reqPc2_q <= '0;
      end else begin
         wrPtr_q  <= wrPtr_d;
         rdPtr_q  <= rdPtr_d;
         count_q  <= count_d;
         reqV_q   <= reqV_d;
         reqPc1_q <= reqPc1_d;
         reqPc2_q <= reqPc2_d;
      end
   end

   // Storage needs no reset; count/pointers alone decide what is visible.
   always_ff @(posedge clk) begin
      if (rst_n && wrEn) begin
         assert (count_q != CNT_W'(DEPTH));
         fifoMem_q[wrPtr_q] <= {reqPc1_q, reqPc2_q, bus.imem_data1_i, bus.imem_data2_i};
      end
   end

   assign headEntry        = fifoMem_q[rdPtr_q];
   assign bus.pc_en_o      = pcEn;
   assign bus.imem_rd_o    = pcEn;
   assign bus.imem_addr1_o = rst_n ? bus.pcF1_i : '0;
   assign bus.imem_addr2_o = rst_n ? bus.pcF2_i : '0;
   assign bus.dec_valid_o  = decValid;
   assign bus.dec_pc1_o    = rst_n ? headEntry.pc1   : '0;
   assign bus.dec_pc2_o    = rst_n ? headEntry.pc2   : '0;
   assign bus.dec_inst1_o  = rst_n ? headEntry.inst1 : '0;
   assign bus.dec_inst2_o  = rst_n ? headEntry.inst2 : '0;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stallCnt_q, stallCnt_d;

   always_comb begin
      stallCnt_d = stallCnt_q;
      if (!pcEn && (stallCnt_q != 32'hFFFF_FFFF)) begin
         stallCnt_d = stallCnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stallCnt_q <= '0;
      end else begin
         stallCnt_q <= stallCnt_d;
      end
   end

   assign fetch_stall_cnt_o = stallCnt_q;
`endif
endmodule

// File: tb/tb_fetch_pair_buffer.sv
// Directed bench for fetch_pair_buffer with a PC-generator model and a synchronous
// instruction memory model; stall counter checks compile in with FETCH_PERF_CNT_EN.
module tb_fetch_pair_buffer;
   localparam int          DEPTH     = 4;
   localparam logic [31:0] BOOT_PC   = 32'h0001_0000;
   localparam logic [31:0] TARGET_PC = 32'h0001_0100;

   logic        clk;
   logic        rst_n;
   logic [31:0] pcQ;
   int          compareCnt  = 0;
   int          mismatchCnt = 0;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stallCnt;
`endif

   fetch_pair_if bus();

   fetch_pair_buffer #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_stall_cnt_o (stallCnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return (addr * 32'd2654435761) ^ 32'hDEAD_BEEF;
   endfunction

   // PC generator: advances by one pair when enabled, loads the redirect target on flush.
   always @(posedge clk) begin
      if (!rst_n) begin
         pcQ <= BOOT_PC;
      end else if (bus.pc_en_o) begin
         pcQ <= bus.flush_i ? TARGET_PC : pcQ + 32'd8;
      end
   end

   assign bus.pcF1_i = pcQ;
   assign bus.pcF2_i = pcQ + 32'd4;

   always @(posedge clk) begin
      if (bus.imem_rd_o) begin
         bus.imem_data1_i <= memWord(bus.imem_addr1_o);
         bus.imem_data2_i <= memWord(bus.imem_addr2_o);
      end
   end

   task automatic applyStimulus(input logic rstVal, input logic flushVal, input logic readyVal);
      @(posedge clk);
      #1;
      rst_n           = rstVal;
      bus.flush_i     = flushVal;
      bus.dec_ready_i = readyVal;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCnt++;
      assert (observed === expected) else begin
         mismatchCnt++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkHead(input string tag, input logic [31:0] pc1);
      checkOutput({tag, ".valid"}, 32'(bus.dec_valid_o), 32'd1);
      checkOutput({tag, ".pc1"},   bus.dec_pc1_o,   pc1);
      checkOutput({tag, ".pc2"},   bus.dec_pc2_o,   pc1 + 32'd4);
      checkOutput({tag, ".inst1"}, bus.dec_inst1_o, memWord(pc1));
      checkOutput({tag, ".inst2"}, bus.dec_inst2_o, memWord(pc1 + 32'd4));
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, ".pcEn"},   32'(bus.pc_en_o),     32'd0);
      checkOutput({tag, ".rd"},     32'(bus.imem_rd_o),   32'd0);
      checkOutput({tag, ".valid"},  32'(bus.dec_valid_o), 32'd0);
      checkOutput({tag, ".addr1"},  bus.imem_addr1_o,     32'd0);
      checkOutput({tag, ".addr2"},  bus.imem_addr2_o,     32'd0);
      checkOutput({tag, ".decPc1"}, bus.dec_pc1_o,        32'd0);
      checkOutput({tag, ".inst2"},  bus.dec_inst2_o,      32'd0);
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.flush_i     = 1'b0;
      bus.dec_ready_i = 1'b0;

      $display("[TB] reset and streaming");
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkResetOutputs("rst");
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("strm.c0.pcEn",  32'(bus.pc_en_o),     32'd1);
      checkOutput("strm.c0.rd",    32'(bus.imem_rd_o),   32'd1);
      checkOutput("strm.c0.addr1", bus.imem_addr1_o,     BOOT_PC);
      checkOutput("strm.c0.addr2", bus.imem_addr2_o,     BOOT_PC + 32'd4);
      checkOutput("strm.c0.valid", 32'(bus.dec_valid_o), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("strm.c1.valid", 32'(bus.dec_valid_o), 32'd0);
      checkOutput("strm.c1.addr1", bus.imem_addr1_o,     BOOT_PC + 32'd8);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         checkHead($sformatf("strm.head%0d", k), BOOT_PC + 32'(8 * k));
         checkOutput($sformatf("strm.pcEn%0d", k), 32'(bus.pc_en_o), 32'd1);
      end

      $display("[TB] stall until full, then drain");
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkOutput($sformatf("fill.pcEn%0d", k), 32'(bus.pc_en_o), 32'd1);
      end
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkOutput($sformatf("full.pcEn%0d", k), 32'(bus.pc_en_o), 32'd0);
         checkHead($sformatf("full.hold%0d", k), BOOT_PC);
      end
      for (int k = 0; k < 7; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         checkOutput($sformatf("drain.pcEn%0d", k), 32'(bus.pc_en_o), (k == 0) ? 32'd0 : 32'd1);
         checkHead($sformatf("drain.head%0d", k), BOOT_PC + 32'(8 * k));
      end

      $display("[TB] flush with queued and in-flight pairs");
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("flush.pcEn",  32'(bus.pc_en_o),     32'd1);
      checkOutput("flush.rd",    32'(bus.imem_rd_o),   32'd1);
      checkOutput("flush.valid", 32'(bus.dec_valid_o), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("flush.f1.valid", 32'(bus.dec_valid_o), 32'd0);
      checkOutput("flush.f1.addr1", bus.imem_addr1_o,     TARGET_PC);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("flush.f2.valid", 32'(bus.dec_valid_o), 32'd0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         checkHead($sformatf("flush.head%0d", k), TARGET_PC + 32'(8 * k));
      end

      $display("[TB] reset while half full");
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
      end
      checkOutput("half.valid", 32'(bus.dec_valid_o), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkResetOutputs("midRst");
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("refetch.valid", 32'(bus.dec_valid_o), 32'd0);
      checkOutput("refetch.pcEn",  32'(bus.pc_en_o),     32'd1);
      checkOutput("refetch.addr1", bus.imem_addr1_o,     BOOT_PC);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("refetch.c1.valid", 32'(bus.dec_valid_o), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkHead("refetch.head0", BOOT_PC);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkHead("refetch.head1", BOOT_PC + 32'd8);

`ifdef FETCH_PERF_CNT_EN
      $display("[TB] stall counter");
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("perf.cleared", stallCnt, 32'd0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
      end
      checkOutput("perf.prefull", stallCnt, 32'd0);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("perf.after10", stallCnt, 32'd10);
      checkOutput("perf.pcEn",    32'(bus.pc_en_o), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("perf.flushCyc", stallCnt, 32'd11);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("perf.keptAfterFlush", stallCnt, 32'd11);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
      $finish;
   end
endmodule
